// File: rtl/operand_seq_pkg.sv
// Shared types and constants for the ALU operand-path sequencer.
package operand_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_SETUP = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WB    = 3'd5
  } state_t;

  localparam logic [15:0] OPC_NOP      = 16'h0000;
  localparam logic [15:0] OPC_IMM_BASE = 16'h0008;

  // Wide enough for any MAX_WAIT in 1..255.
  localparam int TIMER_W = 8;

  // Opcodes at or above the immediate base take muxA in2 (the immediate).
  function automatic logic is_imm(input logic [15:0] opcode);
    return (opcode >= OPC_IMM_BASE);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// ALU completion timer. Loaded on clear, counts down while enabled, and
// flags expiry when the terminal count is reached. Expiry is seen in the
// MAX_WAIT-th enabled cycle after the clear.
module wait_timer
  import operand_seq_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(MAX_WAIT - 1);

  logic [TIMER_W-1:0] count;

  // Down-counter: reload on clear, decrement while enabled, park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= LOAD_VAL;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/operand_seq_ctrl.sv
// Operand-path sequencer: accepts a decoded instruction, reads the register
// file, sets up muxA, starts the ALU, waits for completion with a timeout
// and issues write-back. All outputs are registered from the next state.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for an instruction; NOP is consumed here
//   ST_READ  | register-file read strobe with rs1/rs2 addresses
//   ST_SETUP | muxA select/immediate driven; one cycle for the muxA register
//   ST_EXEC  | ALU start pulse, timer reloaded
//   ST_WAIT  | waiting for alu_done; timer expiry aborts to IDLE with error
//   ST_WB    | write-back strobe with latched rd
module operand_seq_ctrl
  import operand_seq_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int IMM_W    = 16,
  parameter int REG_W    = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic [IMM_W-1:0] instr_imm,
  input  logic [REG_W-1:0] instr_rd,
  input  logic [REG_W-1:0] instr_rs1,
  input  logic [REG_W-1:0] instr_rs2,
  output logic             rf_rd_en,
  output logic [REG_W-1:0] rf_ra,
  output logic [REG_W-1:0] rf_rb,
  output logic             mux_sel,
  output logic [IMM_W-1:0] mux_imm,
  output logic             alu_start,
  output logic [OPC_W-1:0] alu_op,
  input  logic             alu_done,
  output logic             wb_en,
  output logic [REG_W-1:0] wb_rd,
  output logic             busy,
  output logic             err_timeout
);

  state_t state;
  state_t state_next;

  logic [OPC_W-1:0] opc_q;
  logic [IMM_W-1:0] imm_q;
  logic [REG_W-1:0] rd_q;

  logic accept;
  logic is_nop;
  logic timeout_hit;
  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  assign accept      = instr_valid && instr_ready;
  assign is_nop      = (16'(instr_opcode) == OPC_NOP);
  assign timer_clear = (state == ST_EXEC);
  assign timer_en    = (state == ST_WAIT) && !alu_done;

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; alu_done wins over a same-cycle timer expiry.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !is_nop) begin
          state_next = ST_READ;
        end
      end
      ST_READ:  state_next = ST_SETUP;
      ST_SETUP: state_next = ST_EXEC;
      ST_EXEC:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          state_next = ST_WB;
        end else if (timer_expired) begin
          state_next  = ST_IDLE;
          timeout_hit = 1'b1;
        end
      end
      ST_WB:    state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Capture the instruction fields needed after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opc_q <= '0;
      imm_q <= '0;
      rd_q  <= '0;
    end else if (accept && !is_nop) begin
      opc_q <= instr_opcode;
      imm_q <= instr_imm;
      rd_q  <= instr_rd;
    end
  end

  // Registered outputs, decoded from the state being entered so that each
  // strobe is high exactly during its state; data outputs hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_ra       <= '0;
      rf_rb       <= '0;
      mux_sel     <= 1'b1;
      mux_imm     <= '0;
      alu_start   <= 1'b0;
      alu_op      <= '0;
      wb_en       <= 1'b0;
      wb_rd       <= '0;
      err_timeout <= 1'b0;
    end else begin
      instr_ready <= (state_next == ST_IDLE);
      busy        <= (state_next != ST_IDLE);
      rf_rd_en    <= (state_next == ST_READ);
      alu_start   <= (state_next == ST_EXEC);
      wb_en       <= (state_next == ST_WB);
      // READ is only entered from IDLE on a handshake, so the live
      // source indices are the ones being accepted.
      if (state_next == ST_READ) begin
        rf_ra <= instr_rs1;
        rf_rb <= instr_rs2;
      end
      if (state_next == ST_SETUP) begin
        mux_sel <= !is_imm(16'(opc_q));
        mux_imm <= imm_q;
      end
      if (state_next == ST_EXEC) begin
        alu_op <= opc_q;
      end
      if (state_next == ST_WB) begin
        wb_rd <= rd_q;
      end
      if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_seq_ctrl.sv
// Scoreboard bench for operand_seq_ctrl. Stimulus pushes the expected
// strobe events (with their cycle) into a queue; a monitor pops and
// compares whenever the DUT raises rf_rd_en, alu_start, wb_en or
// err_timeout. A small ALU responder answers alu_start after k cycles.
module tb_operand_seq_ctrl;

  localparam int OPC_W = 4;
  localparam int IMM_W = 16;
  localparam int REG_W = 4;
  localparam int MW    = 4;

  localparam int EV_RD = 0;
  localparam int EV_ALU = 1;
  localparam int EV_WB = 2;
  localparam int EV_TO = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [OPC_W-1:0] instr_opcode = '0;
  logic [IMM_W-1:0] instr_imm = '0;
  logic [REG_W-1:0] instr_rd = '0;
  logic [REG_W-1:0] instr_rs1 = '0;
  logic [REG_W-1:0] instr_rs2 = '0;
  logic             rf_rd_en;
  logic [REG_W-1:0] rf_ra;
  logic [REG_W-1:0] rf_rb;
  logic             mux_sel;
  logic [IMM_W-1:0] mux_imm;
  logic             alu_start;
  logic [OPC_W-1:0] alu_op;
  logic             alu_done = 1'b0;
  logic             wb_en;
  logic [REG_W-1:0] wb_rd;
  logic             busy;
  logic             err_timeout;

  operand_seq_ctrl #(
    .OPC_W(OPC_W), .IMM_W(IMM_W), .REG_W(REG_W), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_imm(instr_imm),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .rf_rd_en(rf_rd_en), .rf_ra(rf_ra), .rf_rb(rf_rb),
    .mux_sel(mux_sel), .mux_imm(mux_imm),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic        ms;
    logic [15:0] mi;
  } ev_t;

  ev_t exp_q[$];
  int  k_q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input logic [15:0] a,
                         input logic [15:0] b, input logic ms, input logic [15:0] mi);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b; e.ms = ms; e.mi = mi;
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind, input logic [15:0] a, input logic [15:0] b,
                       input logic ms, input logic [15:0] mi);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d cyc=%0d a=%h required no event", kind, cyc, a);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a !== a || e.b !== b || e.ms !== ms || e.mi !== mi) begin
        failures++;
        $display("FAIL event actual kind=%0d cyc=%0d a=%h b=%h ms=%b mi=%h required kind=%0d cyc=%0d a=%h b=%h ms=%b mi=%h",
                 kind, cyc, a, b, ms, mi, e.kind, e.cyc, e.a, e.b, e.ms, e.mi);
      end
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  logic err_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_rd_en)  match(EV_RD, 16'(rf_ra), 16'(rf_rb), 1'b0, 16'h0);
      if (alu_start) match(EV_ALU, 16'(alu_op), 16'h0, mux_sel, mux_imm);
      if (wb_en)     match(EV_WB, 16'(wb_rd), 16'h0, mux_sel, mux_imm);
      if (err_timeout && !err_prev) match(EV_TO, {14'b0, instr_ready, busy}, 16'h0, 1'b0, 16'h0);
    end
    err_prev = err_timeout;
  end

  // ALU model: alu_done k cycles after alu_start (k=0 never answers).
  int   alu_cnt = 0;
  logic alu_hit;
  logic stray = 1'b0;
  always @(negedge clk) begin
    alu_hit = 1'b0;
    if (rst) begin
      alu_cnt = 0;
    end else begin
      if (alu_cnt > 0) begin
        alu_cnt--;
        if (alu_cnt == 0) alu_hit = 1'b1;
      end
      if (alu_start) alu_cnt = (k_q.size() > 0) ? k_q.pop_front() : 0;
    end
    alu_done = alu_hit | stray;
  end

  // Offer one instruction and return the acceptance edge index (acc is the
  // cycle in which READ is observed). k>0: done after k, k=0: timeout,
  // k<0: no done and no terminal event (used before a reset).
  task automatic issue(input logic [3:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [15:0] imm, input logic ms,
                       input int k, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    instr_valid = 1'b1; instr_opcode = op; instr_imm = imm;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_rd = rd;
    while (!instr_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!instr_ready) begin
      chk("accept_wait_expired", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (op != 4'h0) begin
      k_q.push_back((k < 0) ? 0 : k);
      push_ev(EV_RD, acc, 16'(rs1), 16'(rs2), 1'b0, 16'h0);
      push_ev(EV_ALU, acc + 2, 16'(op), 16'h0, ms, imm);
      if (k > 0) push_ev(EV_WB, acc + 3 + k, 16'(rd), 16'h0, ms, imm);
      else if (k == 0) push_ev(EV_TO, acc + 3 + MW, 16'h0002, 16'h0, 1'b0, 16'h0);
    end
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, {31'b0, (busy || exp_q.size() != 0)}, 32'd0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_instr_ready"}, 32'(instr_ready), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_strobes"}, {29'b0, rf_rd_en, alu_start, wb_en}, 32'd0);
    chk({name, "_mux_sel"}, 32'(mux_sel), 32'd1);
    chk({name, "_mux_imm"}, 32'(mux_imm), 32'd0);
    chk({name, "_addrs"}, {20'b0, rf_ra, rf_rb, wb_rd}, 32'd0);
    chk({name, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({name, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc_a, acc_b;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("idle");

    // Register op: READ acc, EXEC acc+2, WB acc+4.
    issue(4'h3, 4'd2, 4'd5, 4'd7, 16'h1111, 1'b1, 1, acc);
    wait_idle("reg_op");

    // Immediate op, done 3 cycles after start: WB acc+6.
    issue(4'hA, 4'd1, 4'd4, 4'd9, 16'hABCD, 1'b0, 3, acc);
    wait_idle("imm_op");

    // NOP: accepted, no strobes, held values untouched.
    issue(4'h0, 4'd3, 4'd3, 4'd3, 16'h5555, 1'b1, 1, acc);
    repeat (3) @(negedge clk);
    chk("nop_ready", 32'(instr_ready), 32'd1);
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_hold_ra", 32'(rf_ra), 32'd1);
    chk("nop_hold_imm", 32'(mux_imm), 32'hABCD);
    chk("nop_hold_sel", 32'(mux_sel), 32'd0);

    // Stray alu_done while idle is ignored.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_done_busy", 32'(busy), 32'd0);

    // Done in the last WAIT cycle wins over expiry.
    issue(4'h2, 4'd6, 4'd7, 4'd8, 16'h0042, 1'b1, MW, acc);
    wait_idle("boundary");
    chk("boundary_no_err", 32'(err_timeout), 32'd0);

    // Timeout: no done, error after MW WAIT cycles, no write-back.
    issue(4'h5, 4'd1, 4'd2, 4'd3, 16'h0000, 1'b1, 0, acc);
    wait_idle("timeout");
    chk("timeout_flag", 32'(err_timeout), 32'd1);

    // Next instruction runs normally with the flag still set.
    issue(4'hC, 4'd4, 4'd5, 4'd6, 16'h0F0F, 1'b0, 2, acc);
    wait_idle("after_timeout");
    chk("flag_sticky", 32'(err_timeout), 32'd1);

    // Backpressure: second instruction held valid while busy.
    issue(4'h4, 4'd8, 4'd9, 4'd10, 16'h2222, 1'b1, 1, acc_a);
    issue(4'h9, 4'd11, 4'd12, 4'd13, 16'h8001, 1'b0, 1, acc_b);
    chk("b2b_period", 32'(acc_b - acc_a), 32'd6);
    wait_idle("b2b");

    // Reset during WAIT: immediate reset values, no write-back afterwards.
    issue(4'h6, 4'd14, 4'd15, 4'd1, 16'h3333, 1'b1, -1, acc);
    while (cyc < acc + 4) @(negedge clk);
    chk("midop_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("midop");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", {30'b0, instr_ready, busy}, 32'd2);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_seq_ctrl.md
# operand_seq_ctrl

Sequencer for the ALU operand path of the 16-bit RISC core. Accepts one decoded instruction at a time over a valid/ready handshake, reads the register file, and drives the registered operand mux `muxA` through `mux_sel`/`mux_imm`. Waits one cycle for the mux output to settle, starts the ALU, waits for completion with a timeout, and issues write-back. Sits between the decode stage and the `muxA`/ALU/register-file datapath.

## Interface
- `OPC_W`, 4, opcode width
- `IMM_W`, 16, immediate width (drives `muxA` `in2`)
- `REG_W`, 4, register index width
- `MAX_WAIT`, 15, maximum cycles in WAIT before timeout (1..255)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `instr_valid`  in  1  decode presents an instruction
- `instr_ready`  out  1  controller can accept
- `instr_opcode`  in  OPC_W  opcode
- `instr_imm`  in  IMM_W  immediate field
- `instr_rd`, `instr_rs1`, `instr_rs2`  in  REG_W each  destination/source indices
- `rf_rd_en`  out  1  register-file read strobe
- `rf_ra`, `rf_rb`  out  REG_W each  read addresses
- `mux_sel`  out  1  to `muxA.sel`: 1 = register (`in1`), 0 = immediate (`in2`)
- `mux_imm`  out  IMM_W  to `muxA.in2`
- `alu_start`  out  1  one-cycle ALU start pulse
- `alu_op`  out  OPC_W  opcode to ALU
- `alu_done`  in  1  ALU completion, single-cycle pulse
- `wb_en`  out  1  write-back strobe, one cycle
- `wb_rd`  out  REG_W  write-back index
- `busy`  out  1  high in any state except IDLE
- `err_timeout`  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, READ, SETUP, EXEC, WAIT, WB.
- IDLE: `instr_ready`=1. On `instr_valid && instr_ready`, latch all instruction fields. Opcode 0x0 (NOP) stays in IDLE with no other effect. Any other opcode goes to READ.
- READ: `rf_rd_en`=1, `rf_ra`=rs1, `rf_rb`=rs2. Go to SETUP.
- SETUP: drive `mux_sel` (opcode 0x1–0x7 → 1; 0x8–0xF → 0) and `mux_imm`=latched imm. Go to EXEC. The one-cycle dwell covers the `muxA` register.
- EXEC: `alu_start`=1, `alu_op`=latched opcode. Clear the wait counter. Go to WAIT.
- WAIT: on `alu_done`, go to WB. Otherwise increment the counter. When the counter reaches `MAX_WAIT`, set `err_timeout`, return to IDLE, and suppress write-back.
- WB: `wb_en`=1, `wb_rd`=latched rd. Go to IDLE.
- `mux_sel`/`mux_imm` hold their values from SETUP through WB. They change only at the next SETUP.
- `rf_ra`, `rf_rb`, `wb_rd` and `alu_op` hold their last values when not strobed.
- `err_timeout` clears only on `rst`. Later instructions still run normally while it is set.
- `alu_done` outside WAIT is ignored.

## Timing
- Reset values: state IDLE, `instr_ready`=1, `busy`=0, `rf_rd_en`=0, `alu_start`=0, `wb_en`=0, `mux_sel`=1, `mux_imm`=0, `rf_ra`/`rf_rb`/`wb_rd`/`alu_op`=0, `err_timeout`=0.
- Handshake accepted at edge N. Then: READ in cycle N+1, SETUP in N+2, `alu_start` high in N+3, WAIT from N+4.
- `alu_done` in cycle N+3+k (k≥1) gives `wb_en` in N+4+k. Back-to-back minimum period is 6 cycles (k=1).
- Timeout: with no `alu_done`, `err_timeout` rises MAX_WAIT cycles after entering WAIT, and the FSM is in IDLE the next cycle.
- `alu_done` on the same cycle the counter hits MAX_WAIT counts as done: go to WB, no error.
- `instr_valid` while busy is not accepted. Decode must hold it until `instr_ready` is high.
- `rst` asserted mid-operation forces all reset values immediately. The in-flight instruction is dropped and no `wb_en` is issued.
- All outputs are registered.

## Structure
- Package `operand_seq_pkg` contains:
  - the state enum;
  - opcode constants `OPC_NOP`=0x0 and `OPC_IMM_BASE`=0x8;
  - the function `is_imm(opcode)`.
- Sub-module `wait_timer`: counter with clear and enable inputs, `MAX_WAIT` parameter and `expired` output. Instantiated once for WAIT.

## Test plan
- Reset then idle: `rst` pulse → all outputs at reset values, `instr_ready`=1, `busy`=0.
- Register op: opcode 0x3, rs1=2, rs2=5, rd=7, `alu_done` 1 cycle after start → `rf_ra`=2/`rf_rb`=5 at N+1, `mux_sel`=1 at N+2, `alu_start` at N+3, `wb_en` with `wb_rd`=7 at N+5.
- Immediate op: opcode 0xA, imm=0xABCD, `alu_done` after 3 cycles → `mux_sel`=0, `mux_imm`=0xABCD held through WB, `wb_en` at N+7.
- Timeout: MAX_WAIT=4, `alu_done` never asserted → `err_timeout`=1 after 4 WAIT cycles, no `wb_en`. The next instruction completes with the flag still set.
- Reset mid-operation: `rst` during WAIT → immediate IDLE, `wb_en` never pulses, `err_timeout`=0.
- NOP and backpressure: opcode 0x0 is accepted with no strobes. `instr_valid` held high while busy is not accepted until `instr_ready` returns.
